// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit.
// Holds the op-field width and op encodings used by the interface, the top and the bench.
package logic_unit_pkg;

  localparam int unsigned OpWidth   = 3;
  // Zero and parity flags travel alongside the result through the output buffer.
  localparam int unsigned FlagWidth = 2;

  typedef enum logic [OpWidth-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOTA  = 3'd6,
    OP_PASSB = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_if.sv
// Request/response bundle of the logic unit.
// Request side : i_valid/o_ready handshake, i_op, i_acc, i_clr, i_a, i_b.
// Response side: o_valid/i_ready handshake, o_x result, o_zero and o_parity flags.
// Signal names are seen from the logic unit; the slave modport belongs to the unit.
interface logic_unit_if
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) ();

  logic               i_valid;
  logic               o_ready;
  logic [OpWidth-1:0] i_op;
  logic               i_acc;
  logic               i_clr;
  logic [WIDTH-1:0]   i_a;
  logic [WIDTH-1:0]   i_b;
  logic               o_valid;
  logic               i_ready;
  logic [WIDTH-1:0]   o_x;
  logic               o_zero;
  logic               o_parity;

  modport slave (
    input  i_valid, i_op, i_acc, i_clr, i_a, i_b, i_ready,
    output o_ready, o_valid, o_x, o_zero, o_parity
  );

  modport master (
    output i_valid, i_op, i_acc, i_clr, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_x, o_zero, o_parity
  );

endinterface

// File: rtl/logic_unit_skid_buffer.sv
// Two-entry valid/ready buffer: an output register plus one skid entry.
// Ports: i_clk, i_rst_n (sync, active-low), i_valid/o_ready/i_data upstream,
//        o_valid/i_ready/o_data downstream.
// o_ready depends only on registered state, so i_ready never reaches it combinationally.
module skid_buffer #(
  parameter int unsigned       Width     = 10,
  parameter logic [Width-1:0]  ResetData = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [Width-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [Width-1:0] o_data
);

  logic             r_out_valid;
  logic [Width-1:0] r_out_data;
  logic             r_skid_valid;
  logic [Width-1:0] r_skid_data;
  logic             w_accept;

  assign o_ready  = ~r_skid_valid;
  assign w_accept = i_valid & ~r_skid_valid;
  assign o_valid  = r_out_valid;
  assign o_data   = r_out_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= ResetData;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (r_skid_valid) begin
      // Skid full: nothing new is taken; drain the skid once the output moves.
      if (i_ready) begin
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_out_valid || i_ready) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_data;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= i_data;
      end
    end else if (i_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/logic_unit.sv
// Bitwise logic unit with optional accumulator operand and buffered valid/ready output.
// Ports: i_clk, i_rst_n (sync, active-low), bus (logic_unit_if.slave) carrying the
//        request handshake/operands and the result handshake/flags.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  logic_unit_if.slave   bus
);

  localparam int unsigned PayloadWidth = WIDTH + FlagWidth;
  // Reset payload: parity 0, zero 1, result 0.
  localparam logic [PayloadWidth-1:0] PayloadReset = {1'b0, 1'b1, {WIDTH{1'b0}}};

  logic [WIDTH-1:0]        r_acc;
  logic [WIDTH-1:0]        w_a;
  logic [WIDTH-1:0]        w_result;
  logic [PayloadWidth-1:0] w_payload_in;
  logic [PayloadWidth-1:0] w_payload_out;
  logic                    w_sb_ready;
  logic                    w_ready;
  logic                    w_accept;

  assign w_a      = bus.i_acc ? r_acc : bus.i_a;
  assign w_ready  = i_rst_n & w_sb_ready;
  assign w_accept = bus.i_valid & w_ready;

  always_comb begin
    w_result = '0;
    unique case (op_e'(bus.i_op))
      OP_AND:   w_result = w_a & bus.i_b;
      OP_OR:    w_result = w_a | bus.i_b;
      OP_XOR:   w_result = w_a ^ bus.i_b;
      OP_NAND:  w_result = ~(w_a & bus.i_b);
      OP_NOR:   w_result = ~(w_a | bus.i_b);
      OP_XNOR:  w_result = ~(w_a ^ bus.i_b);
      OP_NOTA:  w_result = ~w_a;
      OP_PASSB: w_result = bus.i_b;
      default:  w_result = '0;
    endcase
  end

  // Flags are formed here and registered with the result, so they only change with o_x.
  assign w_payload_in = {^w_result, (w_result == '0), w_result};

  // Accumulator follows acceptance, not output, so chained requests see the right value
  // even while results sit in the buffer. Clear wins over the update.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= bus.i_clr ? '0 : w_result;
    end
  end

  skid_buffer #(
    .Width     (PayloadWidth),
    .ResetData (PayloadReset)
  ) u_skid_buffer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (bus.i_valid),
    .o_ready (w_sb_ready),
    .i_data  (w_payload_in),
    .o_valid (bus.o_valid),
    .i_ready (bus.i_ready),
    .o_data  (w_payload_out)
  );

  assign bus.o_ready  = w_ready;
  assign bus.o_x      = w_payload_out[WIDTH-1:0];
  assign bus.o_zero   = w_payload_out[WIDTH];
  assign bus.o_parity = w_payload_out[WIDTH+1];

endmodule
